// File: rtl/scoreboard_insert.sv
// Sorted leaderboard (descending score) with one-at-a-time candidate insertion.
// Latency: accept at edge E; insert at pos k -> done after edge E+k+2, reject -> done after edge E+DEPTH.
// Backpressure: in_ready is high only in IDLE; in_valid while busy is dropped, not queued.
// Ports: clk/rst (sync active-high), in_valid/in_ready/in_score/in_name candidate handshake,
//        board_score/board_name flattened board (entry 0 = best in LSB slice), done/inserted/rank result.
// Option: define SCOREBOARD_TIE_NEW_EN to let a tied candidate rank above the existing entry.
module scoreboard_insert #(
    parameter int SCORE_SIZE    = 16,
    parameter int ALPHABET_SIZE = 5,
    parameter int DEPTH         = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [SCORE_SIZE-1:0]                in_score,
    input  logic [3*ALPHABET_SIZE-1:0]           in_name,
    output logic [DEPTH*SCORE_SIZE-1:0]          board_score,
    output logic [DEPTH*3*ALPHABET_SIZE-1:0]     board_name,
    output logic                                 done,
    output logic                                 inserted,
    output logic [2:0]                           rank
);
    localparam int NW = 3 * ALPHABET_SIZE;

    typedef enum logic [1:0] {IDLE, SCAN, INSERT, DONE} state_t;

    state_t                state, state_nxt;
    logic [SCORE_SIZE-1:0] sc_q [DEPTH];
    logic [NW-1:0]         nm_q [DEPTH];
    logic [SCORE_SIZE-1:0] cand_score;
    logic [NW-1:0]         cand_name;
    logic [2:0]            idx;
    logic [2:0]            pos;
    logic                  ins_q;
    logic [SCORE_SIZE-1:0] entry_score;
    logic                  win;
    logic                  last_idx;

    // Select entry[idx] with an explicit mux so idx width need not match the array size.
    always_comb begin
        entry_score = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == 3'(i)) entry_score = sc_q[i];
        end
    end

`ifdef SCOREBOARD_TIE_NEW_EN
    assign win = (cand_score >= entry_score);
`else
    assign win = (cand_score > entry_score);
`endif

    assign last_idx = (idx == 3'(DEPTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SCAN;
            SCAN:    if (win) state_nxt = INSERT;
                     else if (last_idx) state_nxt = DONE;
            INSERT:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: candidate latch, scan index, board storage
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_score <= '0;
            cand_name  <= '0;
            idx        <= '0;
            pos        <= '0;
            ins_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                sc_q[i] <= '0;
                nm_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cand_score <= in_score;
                        cand_name  <= in_name;
                        idx        <= '0;
                        pos        <= '0;
                        ins_q      <= 1'b0;
                    end
                end
                SCAN: begin
                    if (win) begin
                        pos   <= idx;
                        ins_q <= 1'b1;
                    end else if (!last_idx) begin
                        idx <= idx + 3'd1;
                    end
                end
                INSERT: begin
                    // Entries below pos move down one slot; the last entry falls off.
                    if (pos == 3'd0) begin
                        sc_q[0] <= cand_score;
                        nm_q[0] <= cand_name;
                    end
                    for (int i = 1; i < DEPTH; i++) begin
                        if (3'(i) == pos) begin
                            sc_q[i] <= cand_score;
                            nm_q[i] <= cand_name;
                        end else if (3'(i) > pos) begin
                            sc_q[i] <= sc_q[i-1];
                            nm_q[i] <= nm_q[i-1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        in_ready = (state == IDLE);
        done     = (state == DONE);
        inserted = 1'b0;
        rank     = 3'd0;
        if (state == DONE && ins_q) begin
            inserted = 1'b1;
            rank     = pos;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign board_score[g*SCORE_SIZE +: SCORE_SIZE] = sc_q[g];
        assign board_name[g*NW +: NW]                  = nm_q[g];
    end

endmodule

// File: tb/tb_scoreboard_insert.sv
module tb_scoreboard_insert;
    localparam int SS = 16;
    localparam int AS = 5;
    localparam int D  = 3;
    localparam int NW = 3 * AS;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [SS-1:0]     in_score;
    logic [NW-1:0]     in_name;
    logic [D*SS-1:0]   board_score;
    logic [D*NW-1:0]   board_name;
    logic              done;
    logic              inserted;
    logic [2:0]        rank;

    scoreboard_insert #(.SCORE_SIZE(SS), .ALPHABET_SIZE(AS), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_score(in_score), .in_name(in_name),
        .board_score(board_score), .board_name(board_name),
        .done(done), .inserted(inserted), .rank(rank)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [SS-1:0]   score;
        logic [NW-1:0]   name;
        logic            ins;
        logic [2:0]      rank;
        int              lat;
        logic [D*SS-1:0] sc;
        logic [D*NW-1:0] nm;
    } vec_t;

    vec_t v [8];

    // Present one candidate; returns edges from acceptance to the done cycle (-1 on timeout).
    task automatic run_insert(input logic [SS-1:0] s, input logic [NW-1:0] n, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1;
        in_score = s;
        in_name  = n;
        @(posedge clk); #1;          // acceptance edge E
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 30);
        if (!done) lat = -1;
    endtask

    initial begin
        int lat;
        int cnt;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_score = '0;
        in_name  = '0;

        // Sequence builds {10,0,0} -> {15,10,0} -> {15,10,7} -> {20,15,10}, then probes ties and extremes.
        v[0] = '{16'd10, 15'd1, 1'b1, 3'd0, 2, {16'd0, 16'd0, 16'd10}, {15'd0, 15'd0, 15'd1}};
        v[1] = '{16'd15, 15'd2, 1'b1, 3'd0, 2, {16'd0, 16'd10, 16'd15}, {15'd0, 15'd1, 15'd2}};
        v[2] = '{16'd7,  15'd3, 1'b1, 3'd2, 4, {16'd7, 16'd10, 16'd15}, {15'd3, 15'd1, 15'd2}};
        v[3] = '{16'd20, 15'd4, 1'b1, 3'd0, 2, {16'd10, 16'd15, 16'd20}, {15'd1, 15'd2, 15'd4}};
        v[4] = '{16'd5,  15'd5, 1'b0, 3'd0, 3, {16'd10, 16'd15, 16'd20}, {15'd1, 15'd2, 15'd4}};
`ifdef SCOREBOARD_TIE_NEW_EN
        v[5] = '{16'd15, 15'd33, 1'b1, 3'd1, 3, {16'd15, 16'd15, 16'd20}, {15'd2, 15'd33, 15'd4}};
        v[6] = '{16'd0,  15'd6,  1'b0, 3'd0, 3, {16'd15, 16'd15, 16'd20}, {15'd2, 15'd33, 15'd4}};
        v[7] = '{16'hFFFF, 15'd7, 1'b1, 3'd0, 2, {16'd15, 16'd20, 16'hFFFF}, {15'd33, 15'd4, 15'd7}};
`else
        v[5] = '{16'd15, 15'd33, 1'b1, 3'd2, 4, {16'd15, 16'd15, 16'd20}, {15'd33, 15'd2, 15'd4}};
        v[6] = '{16'd0,  15'd6,  1'b0, 3'd0, 3, {16'd15, 16'd15, 16'd20}, {15'd33, 15'd2, 15'd4}};
        v[7] = '{16'hFFFF, 15'd7, 1'b1, 3'd0, 2, {16'd15, 16'd20, 16'hFFFF}, {15'd2, 15'd4, 15'd7}};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset done", 64'(done), 64'd0);
        check("reset inserted", 64'(inserted), 64'd0);
        check("reset rank", 64'(rank), 64'd0);
        check("reset board_score", 64'(board_score), 64'd0);
        check("reset board_name", 64'(board_name), 64'd0);

        // Table-driven inserts
        for (int i = 0; i < 8; i++) begin
            run_insert(v[i].score, v[i].name, lat);
            check($sformatf("v%0d latency", i), 64'(lat), 64'(v[i].lat));
            check($sformatf("v%0d inserted", i), 64'(inserted), 64'(v[i].ins));
            check($sformatf("v%0d rank", i), 64'(rank), 64'(v[i].rank));
            check($sformatf("v%0d board_score", i), 64'(board_score), 64'(v[i].sc));
            check($sformatf("v%0d board_name", i), 64'(board_name), 64'(v[i].nm));
            @(posedge clk); #1;
            check($sformatf("v%0d done pulse width", i), 64'(done), 64'd0);
            check($sformatf("v%0d inserted after done", i), 64'(inserted), 64'd0);
            check($sformatf("v%0d in_ready after done", i), 64'(in_ready), 64'd1);
        end

        // in_valid during SCAN is dropped
        in_valid = 1'b1; in_score = 16'd3; in_name = 15'd8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;          // SCAN, idx=1
        check("scan in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_score = 16'd999; in_name = 15'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 2;
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy pulse latency", 64'(lat), 64'd3);
        check("busy pulse inserted", 64'(inserted), 64'd0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        check("busy pulse extra done", 64'(cnt), 64'd0);
        check("busy pulse board_score", 64'(board_score), 64'(v[7].sc));
        check("busy pulse board_name", 64'(board_name), 64'(v[7].nm));

        // Reset during SCAN aborts the candidate
        in_valid = 1'b1; in_score = 16'd50; in_name = 15'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;          // SCAN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort done", 64'(done), 64'd0);
        check("abort board_score", 64'(board_score), 64'd0);
        check("abort board_name", 64'(board_name), 64'd0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        check("abort no done", 64'(cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
